clock_gate_ctrl: RTL and testbench
==================================

CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CNT_WIDTH, default 8, width of the idle counter and threshold.
REQ-002 SHALL have parameter WAKE_DELAY, default 2, number of enabled-clock cycles between ungating and wake acknowledge (1..15).
REQ-003 SHALL have port clk_i  input  1  free-running (ungated) clock; the block itself is never gated.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port gate_en_i  input  1  software enable for automatic gating; 0 forces the clock on.
REQ-006 SHALL have port busy_i  input  1  activity indication from the gated domain.
REQ-007 SHALL have port wake_req_i  input  1  external wake event (e.g. interrupt, bus request), level.
REQ-008 SHALL have port idle_thresh_i  input  IDLE_CNT_WIDTH  idle cycles required before gating; held static during operation.
REQ-009 SHALL have port clk_en_o  output  1  registered enable to the clock-gating cell en input.
REQ-010 SHALL have port wake_ack_o  output  1  one-cycle pulse: gated domain clock stable after wake.
REQ-011 SHALL have port gated_o  output  1  status, high while the clock is gated.

Function
REQ-012 SHALL implement FSM states ACTIVE, COUNT, GATED, WAKE; all outputs driven from registers.
REQ-013 ACTIVE: clk_en_o=1; SHALL go to COUNT with idle counter cleared when gate_en_i=1, busy_i=0, wake_req_i=0.
REQ-014 COUNT: clk_en_o=1; idle counter increments each cycle, never wraps (saturates at all-ones).
REQ-015 COUNT: busy_i=1 or wake_req_i=1 or gate_en_i=0 SHALL return to ACTIVE next cycle; this abort has priority over gating.
REQ-016 COUNT: when idle counter == idle_thresh_i and no abort condition, SHALL go to GATED; idle_thresh_i=0 gives exactly one COUNT cycle.
REQ-017 Idle-to-gate latency: clk_en_o falls idle_thresh_i+2 cycles after the first cycle satisfying REQ-013.
REQ-018 GATED: clk_en_o=0, gated_o=1; wake_req_i=1 or busy_i=1 or gate_en_i=0 SHALL go to WAKE with wake counter cleared.
REQ-019 WAKE: clk_en_o=1, gated_o=0; wake counter increments; at count WAKE_DELAY-1 SHALL pulse wake_ack_o for one cycle and go to ACTIVE.
REQ-020 WAKE SHALL not be aborted by any input; a new gating sequence only starts from ACTIVE.
REQ-021 wake_ack_o SHALL be asserted only on the WAKE-to-ACTIVE transition cycle and never twice per wake.
REQ-022 Simultaneous wake_req_i and gate condition in ACTIVE SHALL keep ACTIVE.

Reset
REQ-023 On rst_ni=0 SHALL immediately enter ACTIVE: clk_en_o=1, wake_ack_o=0, gated_o=0, counters 0.
REQ-024 Reset asserted mid-COUNT, GATED or WAKE SHALL abandon the sequence without emitting wake_ack_o.
REQ-025 After reset release, the first gating decision SHALL occur no earlier than the first clk_i rising edge.

Structure
REQ-026 State enumeration typedef and WAKE_DELAY counter width constant (4 bits) SHALL reside in a shared package clock_gate_pkg.
REQ-027 SHALL be a single module; the existing clock-gating cell is instantiated by the parent, not inside this block.

Verification
REQ-028 Thresh=3, gate_en_i=1, busy_i falls at cycle 10 -> clk_en_o=0 from cycle 15, gated_o=1.
REQ-029 Thresh=3, busy_i pulses high at third COUNT cycle -> state ACTIVE, clk_en_o stays 1, restart counting from 0 after busy_i falls.
REQ-030 GATED, wake_req_i 1-cycle pulse at cycle 20, WAKE_DELAY=2 -> clk_en_o=1 at 21, wake_ack_o pulse at 22, ACTIVE at 23.
REQ-031 Thresh=0 -> one COUNT cycle then GATED; gate_en_i=0 in GATED -> WAKE then ACTIVE with single wake_ack_o.
REQ-032 rst_ni asserted during WAKE -> clk_en_o=1 asynchronously, no wake_ack_o, ACTIVE after release.
REQ-033 Thresh=255 with idle hold of 300 cycles -> gating at 257, counter never wraps.

Source files
------------

// File: rtl/clock_gate_pkg.sv
// Shared types and constants for the clock-gating controller.
package clock_gate_pkg;

  // Width of the wake-delay counter. It must hold WAKE_DELAY-1 for WAKE_DELAY up to 15.
  localparam int unsigned WAKE_CNT_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_COUNT  = 2'd1,
    ST_GATED  = 2'd2,
    ST_WAKE   = 2'd3
  } cg_state_e;

endpackage

// File: rtl/clock_gate_ctrl.sv
// Automatic clock-gating controller. After a programmable number of idle
// cycles it drops the enable to an external clock-gating cell. On a wake
// event it restores the enable and acknowledges once the gated clock is
// stable. The block runs on the free-running clock and is never gated.
//
// Ports:
//   clk_i         free-running clock
//   rst_ni        asynchronous active-low reset
//   gate_en_i     software enable for automatic gating (0 forces the clock on)
//   busy_i        activity from the gated domain
//   wake_req_i    external wake event (level)
//   idle_thresh_i idle cycles required before gating (held static)
//   clk_en_o      registered enable to the clock-gating cell
//   wake_ack_o    one-cycle pulse when the clock is stable after a wake
//   gated_o       high while the clock is gated
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int unsigned IDLE_CNT_WIDTH = 8,
  parameter int unsigned WAKE_DELAY     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      gate_en_i,
  input  logic                      busy_i,
  input  logic                      wake_req_i,
  input  logic [IDLE_CNT_WIDTH-1:0] idle_thresh_i,
  output logic                      clk_en_o,
  output logic                      wake_ack_o,
  output logic                      gated_o
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_DELAY - 1);

  cg_state_e                 state_q, state_d;
  logic [IDLE_CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0]     wake_cnt_q, wake_cnt_d;
  logic                      clk_en_d, wake_ack_d, gated_d;
  logic                      gate_cond;

  // Idle condition. Its negation is both the COUNT abort and the GATED wake trigger.
  assign gate_cond = gate_en_i & ~busy_i & ~wake_req_i;

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      clk_en_o   <= 1'b1;
      wake_ack_o <= 1'b0;
      gated_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_o   <= clk_en_d;
      wake_ack_o <= wake_ack_d;
      gated_o    <= gated_d;
    end
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;

    unique case (state_q)
      ST_ACTIVE: begin
        idle_cnt_d = '0;
        // A pending wake request overrides the gate condition, so the FSM stays here.
        if (gate_cond) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        // An abort takes priority over reaching the threshold.
        if (!gate_cond) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == idle_thresh_i) begin
          state_d = ST_GATED;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + IDLE_CNT_WIDTH'(1);
        end
      end
      ST_GATED: begin
        if (!gate_cond) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // No input can abort the wake sequence.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_ACTIVE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_ACTIVE;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    // Outputs describe the upcoming state, so the output registers stay aligned with state_q.
    clk_en_d   = (state_d != ST_GATED);
    gated_d    = (state_d == ST_GATED);
    wake_ack_d = (state_d == ST_WAKE) && (wake_cnt_d == WAKE_LAST);
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed testbench for clock_gate_ctrl (IDLE_CNT_WIDTH=8, WAKE_DELAY=2).
// Cycle n is the interval after the n-th rising clock edge. Inputs are
// driven, and outputs sampled, 1 ns after that edge.
module tb_clock_gate_ctrl;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       gate_en  = 1'b1;
  logic       busy     = 1'b1;
  logic       wake_req = 1'b0;
  logic [7:0] thresh   = 8'd3;
  logic       clk_en;
  logic       wake_ack;
  logic       gated;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  clock_gate_ctrl #(
    .IDLE_CNT_WIDTH(8),
    .WAKE_DELAY    (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .gate_en_i    (gate_en),
    .busy_i       (busy),
    .wake_req_i   (wake_req),
    .idle_thresh_i(thresh),
    .clk_en_o     (clk_en),
    .wake_ack_o   (wake_ack),
    .gated_o      (gated)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // Advance to 1 ns after rising edge n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, applied before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_clk_en", clk_en, 1'b1);
    chk("rst_ack", wake_ack, 1'b0);
    chk("rst_gated", gated, 1'b0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    chk("busy_active", clk_en, 1'b1);

    // thresh=3: busy falls at cycle 10, so gating starts at cycle 15
    wait_cyc(10); busy = 1'b0;
    wait_cyc(14); chk("lat_pre", clk_en, 1'b1);
    wait_cyc(15); chk("lat_clk_en", clk_en, 1'b0); chk("lat_gated", gated, 1'b1);

    // Wake pulse at cycle 20: clock on at 21, ack at 22, ACTIVE at 23
    wait_cyc(20); wake_req = 1'b1; chk("gated_hold", clk_en, 1'b0);
    wait_cyc(21); wake_req = 1'b0;
    chk("wake_clk_en", clk_en, 1'b1); chk("wake_gated", gated, 1'b0); chk("wake_ack_early", wake_ack, 1'b0);
    wait_cyc(22); chk("wake_ack", wake_ack, 1'b1);
    wait_cyc(23); chk("wake_ack_drop", wake_ack, 1'b0); chk("wake_active", clk_en, 1'b1);
    // ACTIVE at 23 with idle inputs, so the next gating happens at 28
    wait_cyc(27); chk("regate_pre", clk_en, 1'b1);
    wait_cyc(28); chk("regate", clk_en, 1'b0);

    // busy wakes the block from GATED
    wait_cyc(30); busy = 1'b1;
    wait_cyc(31); chk("busy_wake_en", clk_en, 1'b1);
    wait_cyc(32); chk("busy_wake_ack", wake_ack, 1'b1);
    wait_cyc(33); chk("busy_wake_ack_drop", wake_ack, 1'b0);

    // COUNT runs at 41..43, busy aborts at the third COUNT cycle, counting restarts at 45
    wait_cyc(40); busy = 1'b0;
    wait_cyc(43); busy = 1'b1;
    wait_cyc(44); busy = 1'b0; chk("abort_en", clk_en, 1'b1);
    wait_cyc(45); chk("abort_no_gate", clk_en, 1'b1);
    wait_cyc(48); chk("restart_pre", clk_en, 1'b1);
    wait_cyc(49); chk("restart_gate", clk_en, 1'b0); chk("restart_gated", gated, 1'b1);

    // gate_en=0 wakes the block from GATED
    wait_cyc(50); gate_en = 1'b0;
    wait_cyc(51); chk("sw_wake_en", clk_en, 1'b1);
    wait_cyc(52); chk("sw_wake_ack", wake_ack, 1'b1);
    wait_cyc(53); chk("sw_wake_ack_drop", wake_ack, 1'b0);
    wait_cyc(55); chk("forced_on", clk_en, 1'b1); thresh = 8'd0;

    // thresh=0: one COUNT cycle, then GATED
    wait_cyc(56); gate_en = 1'b1;
    wait_cyc(57); chk("t0_count", clk_en, 1'b1);
    wait_cyc(58); chk("t0_gate", clk_en, 1'b0); chk("t0_gated", gated, 1'b1);
    wait_cyc(60); gate_en = 1'b0;
    wait_cyc(61); chk("t0_wake_en", clk_en, 1'b1); chk("t0_wake_gated", gated, 1'b0); chk("t0_ack_early", wake_ack, 1'b0);
    wait_cyc(62); chk("t0_ack", wake_ack, 1'b1);
    wait_cyc(63); chk("t0_ack_drop", wake_ack, 1'b0);
    wait_cyc(64); chk("t0_ack_once", wake_ack, 1'b0);

    // A wake request present together with the gate condition keeps ACTIVE
    wait_cyc(65); gate_en = 1'b1; wake_req = 1'b1;
    wait_cyc(69); chk("simul_en", clk_en, 1'b1); chk("simul_gated", gated, 1'b0);
    wait_cyc(70); wake_req = 1'b0;
    wait_cyc(71); chk("simul_count", clk_en, 1'b1);
    wait_cyc(72); chk("simul_gate", clk_en, 1'b0);

    // WAKE ignores the gate condition; a new sequence starts only from ACTIVE
    wait_cyc(75); wake_req = 1'b1;
    wait_cyc(76); wake_req = 1'b0; chk("noabort_en", clk_en, 1'b1);
    wait_cyc(77); chk("noabort_ack", wake_ack, 1'b1);
    wait_cyc(78); chk("noabort_ack_drop", wake_ack, 1'b0); chk("noabort_active", clk_en, 1'b1);
    wait_cyc(79); chk("noabort_count", clk_en, 1'b1);
    wait_cyc(80); chk("noabort_gate", clk_en, 1'b0);

    // Reset asserted during WAKE: no ack, ACTIVE after release
    wait_cyc(85); wake_req = 1'b1;
    wait_cyc(86); wake_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_en", clk_en, 1'b1); chk("rstw_gated", gated, 1'b0); chk("rstw_ack", wake_ack, 1'b0);
    wait_cyc(87); chk("rstw_ack_87", wake_ack, 1'b0);
    wait_cyc(88); chk("rstw_ack_88", wake_ack, 1'b0);
    wait_cyc(89); rst_n = 1'b1;
    wait_cyc(90); chk("rstw_count", clk_en, 1'b1);
    wait_cyc(91); chk("rstw_regate", clk_en, 1'b0); chk("rstw_regated", gated, 1'b1);

    // Reset asserted in GATED acts without a clock edge
    #2 rst_n = 1'b0; gate_en = 1'b0;
    #1;
    chk("rstg_async_en", clk_en, 1'b1); chk("rstg_async_gated", gated, 1'b0);
    wait_cyc(93); rst_n = 1'b1;
    wait_cyc(95); chk("rstg_en", clk_en, 1'b1); chk("rstg_ack", wake_ack, 1'b0);

    // thresh=255 under a long idle hold: gating at cycle 100+257
    wait_cyc(100); thresh = 8'd255; gate_en = 1'b1;
    wait_cyc(356); chk("t255_pre", clk_en, 1'b1);
    wait_cyc(357); chk("t255_gate", clk_en, 1'b0); chk("t255_gated", gated, 1'b1);
    wait_cyc(400); chk("t255_hold", clk_en, 1'b0); chk("t255_hold_gated", gated, 1'b1);
    wake_req = 1'b1;
    wait_cyc(401); wake_req = 1'b0; gate_en = 1'b0;
    wait_cyc(402); chk("t255_ack", wake_ack, 1'b1);
    wait_cyc(403); chk("t255_ack_drop", wake_ack, 1'b0); chk("t255_active", clk_en, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
